// File: rtl/rename_regfile_if.sv
// rename_regfile_if: operand lookup, dispatch, commit and checkpoint signals of the rename register file.
interface rename_regfile_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 4,
    parameter int NRP   = 2,
    parameter int NCKPT = 2
);
    localparam int RW = $clog2(NREG);
    localparam int CW = NCKPT > 1 ? $clog2(NCKPT) : 1;
    logic                  rdy;
    logic                  flush;
    logic [NRP-1:0]        rd_en;
    logic [NRP*RW-1:0]     rd_addr;
    logic [NRP-1:0]        rd_valid;
    logic [NRP-1:0]        rd_busy;
    logic [NRP*XLEN-1:0]   rd_data;
    logic                  disp_en;
    logic [RW-1:0]         disp_rd;
    logic [TAG_W-1:0]      disp_tag;
    logic                  cmt_en;
    logic [RW-1:0]         cmt_rd;
    logic [TAG_W-1:0]      cmt_tag;
    logic [XLEN-1:0]       cmt_data;
    logic                  ck_save;
    logic [CW-1:0]         ck_save_id;
    logic                  ck_restore;
    logic [CW-1:0]         ck_restore_id;

    modport master (
        output rdy, flush, rd_en, rd_addr, disp_en, disp_rd, disp_tag,
               cmt_en, cmt_rd, cmt_tag, cmt_data, ck_save, ck_save_id, ck_restore, ck_restore_id,
        input  rd_valid, rd_busy, rd_data
    );
    modport slave (
        input  rdy, flush, rd_en, rd_addr, disp_en, disp_rd, disp_tag,
               cmt_en, cmt_rd, cmt_tag, cmt_data, ck_save, ck_save_id, ck_restore, ck_restore_id,
        output rd_valid, rd_busy, rd_data
    );
endinterface

// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with ROB-tag renaming, commit bypass and branch checkpoints.
module rename_regfile #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 4,
    parameter int NRP   = 2,
    parameter int NCKPT = 2
) (
    input logic clk,
    input logic rst,
    rename_regfile_if.slave rf
);
    localparam int RW = $clog2(NREG);

    logic [XLEN-1:0]  v_q [NREG];
    logic [XLEN-1:0]  v_d [NREG];
    logic [NREG-1:0]  b_q, b_d;
    logic [TAG_W-1:0] q_q [NREG];
    logic [TAG_W-1:0] q_d [NREG];
    logic [NREG-1:0]  cb_q [NCKPT];
    logic [NREG-1:0]  cb_d [NCKPT];
    logic [TAG_W-1:0] cq_q [NCKPT][NREG];
    logic [TAG_W-1:0] cq_d [NCKPT][NREG];
    logic cmt, disp, save, rest, v_wr;

    always_comb begin
        cmt  = rf.cmt_en && rf.rdy && rf.cmt_rd != '0;
        disp = rf.disp_en && rf.rdy && rf.disp_rd != '0;
        save = rf.ck_save && rf.rdy && int'(rf.ck_save_id) < NCKPT;
        rest = rf.ck_restore && rf.rdy && int'(rf.ck_restore_id) < NCKPT;
        v_wr = rf.cmt_en && rf.cmt_rd != '0 && (rf.rdy || rf.flush);
        v_d  = v_q;
        b_d  = b_q;
        q_d  = q_q;
        cb_d = cb_q;
        cq_d = cq_q;
        if (v_wr)
            v_d[rf.cmt_rd] = rf.cmt_data;
        for (int c = 0; c < NCKPT; c++)
            if (cmt && cq_q[c][rf.cmt_rd] == rf.cmt_tag)
                cb_d[c][rf.cmt_rd] = 1'b0;
        if (rf.flush) begin
            b_d = '0;
            for (int c = 0; c < NCKPT; c++)
                cb_d[c] = '0;
        end else if (rest) begin
            // the restored snapshot already carries this cycle's commit clear
            b_d = cb_d[rf.ck_restore_id];
            q_d = cq_q[rf.ck_restore_id];
        end else begin
            if (cmt && q_q[rf.cmt_rd] == rf.cmt_tag)
                b_d[rf.cmt_rd] = 1'b0;
            if (disp) begin
                b_d[rf.disp_rd] = 1'b1;
                q_d[rf.disp_rd] = rf.disp_tag;
            end
            if (save) begin
                cb_d[rf.ck_save_id] = b_d;
                cq_d[rf.ck_save_id] = q_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q  <= '{default: '0};
            b_q  <= '0;
            cb_q <= '{default: '0};
        end else begin
            v_q  <= v_d;
            b_q  <= b_d;
            q_q  <= q_d;
            cb_q <= cb_d;
            cq_q <= cq_d;
        end
    end

    // register 0 is never marked busy, so its lookup falls through to v_q[0], which stays 0
    for (genvar r = 0; r < NRP; r++) begin : g_rd
        logic [RW-1:0] a;
        logic en, byp, pend;
        assign a    = rf.rd_addr[r*RW +: RW];
        assign en   = rf.rd_en[r] && !rst && !rf.flush;
        assign byp  = cmt && rf.cmt_rd == a && rf.cmt_tag == q_q[a];
        assign pend = b_q[a] && !byp;
        assign rf.rd_valid[r] = en;
        assign rf.rd_busy[r]  = en && pend;
        assign rf.rd_data[r*XLEN +: XLEN] = !en ? '0 : pend ? XLEN'(q_q[a]) : b_q[a] ? rf.cmt_data : v_q[a];
    end
endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed vector table plus randomized run against a behavioural rename model.
module tb_rename_regfile;
    localparam int NCK = 3;
    logic clk, rst;
    int checks = 0, errors = 0;

    rename_regfile_if #(.NCKPT(NCK)) rf();
    rename_regfile #(.NCKPT(NCK)) dut (.clk(clk), .rst(rst), .rf(rf.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit [31:0] mv [32];
    bit        mb [32];
    bit [3:0]  mq [32];
    bit        cb [NCK][32];
    bit [3:0]  cq [NCK][32];

    typedef struct {
        int rdy, flush, de, drd, dtag, ce, crd, ctag;
        logic [31:0] cdata;
        int sv, svid, rs, rsid, en, a0, a1, ev, eb;
        logic [31:0] ed0, ed1;
    } vec_t;
    vec_t tbl [27];

    task automatic model_step();
        bit com;
        if (rst) begin
            foreach (mv[i]) begin mv[i] = 0; mb[i] = 0; end
            foreach (cb[c, i]) cb[c][i] = 0;
            return;
        end
        if (rf.flush) begin
            if (rf.cmt_en && rf.cmt_rd != 0) mv[rf.cmt_rd] = rf.cmt_data;
            foreach (mb[i]) mb[i] = 0;
            foreach (cb[c, i]) cb[c][i] = 0;
            return;
        end
        if (!rf.rdy) return;
        com = rf.cmt_en && rf.cmt_rd != 0;
        if (com) begin
            mv[rf.cmt_rd] = rf.cmt_data;
            for (int c = 0; c < NCK; c++)
                if (cq[c][rf.cmt_rd] == rf.cmt_tag) cb[c][rf.cmt_rd] = 0;
        end
        if (rf.ck_restore && rf.ck_restore_id < NCK) begin
            mb = cb[rf.ck_restore_id];
            mq = cq[rf.ck_restore_id];
            return;
        end
        if (com && mq[rf.cmt_rd] == rf.cmt_tag) mb[rf.cmt_rd] = 0;
        if (rf.disp_en && rf.disp_rd != 0) begin
            mb[rf.disp_rd] = 1;
            mq[rf.disp_rd] = rf.disp_tag;
        end
        if (rf.ck_save && rf.ck_save_id < NCK) begin
            cb[rf.ck_save_id] = mb;
            cq[rf.ck_save_id] = mq;
        end
    endtask

    task automatic exp_rd(input int p, output logic v, output logic b, output logic [31:0] d);
        logic [4:0] a;
        a = rf.rd_addr[p*5 +: 5];
        v = 0; b = 0; d = 0;
        if (!rf.rd_en[p] || rst || rf.flush) return;
        v = 1;
        if (a == 0 || !mb[a]) d = mv[a];
        else if (rf.cmt_en && rf.rdy && rf.cmt_rd == a && rf.cmt_tag == mq[a]) d = rf.cmt_data;
        else begin b = 1; d = 32'(mq[a]); end
    endtask

    task automatic chk(input string nm, input int p, input logic v, input logic b, input logic [31:0] d);
        logic gv, gb;
        logic [31:0] gd;
        gv = rf.rd_valid[p];
        gb = rf.rd_busy[p];
        gd = rf.rd_data[p*32 +: 32];
        checks++;
        if (gv !== v || gb !== b || gd !== d) begin
            errors++;
            $display("FAIL %s port%0d: got valid=%0b busy=%0b data=%h, want valid=%0b busy=%0b data=%h",
                     nm, p, gv, gb, gd, v, b, d);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        rf.rdy = 1'b1; rf.flush = 1'b0; rf.rd_en = '0; rf.rd_addr = '0;
        rf.disp_en = 1'b0; rf.disp_rd = '0; rf.disp_tag = '0;
        rf.cmt_en = 1'b0; rf.cmt_rd = '0; rf.cmt_tag = '0; rf.cmt_data = '0;
        rf.ck_save = 1'b0; rf.ck_save_id = '0; rf.ck_restore = 1'b0; rf.ck_restore_id = '0;
    endtask

    task automatic apply(input vec_t t);
        rf.rdy = 1'(t.rdy); rf.flush = 1'(t.flush);
        rf.disp_en = 1'(t.de); rf.disp_rd = 5'(t.drd); rf.disp_tag = 4'(t.dtag);
        rf.cmt_en = 1'(t.ce); rf.cmt_rd = 5'(t.crd); rf.cmt_tag = 4'(t.ctag); rf.cmt_data = t.cdata;
        rf.ck_save = 1'(t.sv); rf.ck_save_id = 2'(t.svid);
        rf.ck_restore = 1'(t.rs); rf.ck_restore_id = 2'(t.rsid);
        rf.rd_en = 2'(t.en); rf.rd_addr = {5'(t.a1), 5'(t.a0)};
    endtask

    initial begin
        logic v, b;
        logic [31:0] d;
        tbl[0]  = '{1,0, 1,5,3,  0,0,0,32'h0,        0,0,0,0, 3,5,0,  3,0,32'h0,32'h0};
        tbl[1]  = '{1,0, 0,0,0,  0,0,0,32'h0,        0,0,0,0, 3,5,0,  3,1,32'h3,32'h0};
        tbl[2]  = '{1,0, 0,0,0,  1,5,3,32'hDEADBEEF, 0,0,0,0, 3,5,6,  3,0,32'hDEADBEEF,32'h0};
        tbl[3]  = '{1,0, 0,0,0,  0,0,0,32'h0,        0,0,0,0, 3,5,6,  3,0,32'hDEADBEEF,32'h0};
        tbl[4]  = '{1,0, 1,5,3,  0,0,0,32'h0,        0,0,0,0, 3,5,6,  3,0,32'hDEADBEEF,32'h0};
        tbl[5]  = '{1,0, 1,5,7,  0,0,0,32'h0,        0,0,0,0, 3,5,6,  3,1,32'h3,32'h0};
        tbl[6]  = '{1,0, 0,0,0,  1,5,3,32'h11,       0,0,0,0, 3,5,6,  3,1,32'h7,32'h0};
        tbl[7]  = '{1,0, 0,0,0,  0,0,0,32'h0,        0,0,0,0, 3,5,6,  3,1,32'h7,32'h0};
        tbl[8]  = '{1,0, 1,6,2,  0,0,0,32'h0,        0,0,0,0, 3,6,5,  3,2,32'h0,32'h7};
        tbl[9]  = '{1,0, 1,6,4,  1,6,2,32'h66,       0,0,0,0, 3,6,5,  3,2,32'h66,32'h7};
        tbl[10] = '{1,0, 0,0,0,  0,0,0,32'h0,        0,0,0,0, 3,6,5,  3,3,32'h4,32'h7};
        tbl[11] = '{1,0, 1,8,1,  0,0,0,32'h0,        0,0,0,0, 3,8,7,  3,0,32'h0,32'h0};
        tbl[12] = '{1,0, 0,0,0,  0,0,0,32'h0,        1,1,0,0, 3,8,7,  3,1,32'h1,32'h0};
        tbl[13] = '{1,0, 1,7,5,  0,0,0,32'h0,        0,0,0,0, 3,8,7,  3,1,32'h1,32'h0};
        tbl[14] = '{1,0, 0,0,0,  1,8,1,32'h88,       0,0,0,0, 3,8,7,  3,2,32'h88,32'h5};
        tbl[15] = '{1,0, 0,0,0,  0,0,0,32'h0,        0,0,1,1, 3,8,7,  3,2,32'h88,32'h5};
        tbl[16] = '{1,0, 0,0,0,  0,0,0,32'h0,        0,0,0,0, 3,8,7,  3,0,32'h88,32'h0};
        tbl[17] = '{1,0, 0,0,0,  0,0,0,32'h0,        0,0,0,0, 3,6,5,  3,3,32'h4,32'h7};
        tbl[18] = '{1,0, 1,10,9, 0,0,0,32'h0,        1,3,0,0, 3,10,5, 3,2,32'h0,32'h7};
        tbl[19] = '{1,0, 0,0,0,  0,0,0,32'h0,        0,0,1,3, 3,10,5, 3,3,32'h9,32'h7};
        tbl[20] = '{1,0, 0,0,0,  0,0,0,32'h0,        0,0,0,0, 3,10,5, 3,3,32'h9,32'h7};
        tbl[21] = '{0,0, 1,11,2, 1,10,9,32'h10,      0,0,0,0, 3,10,11,3,1,32'h9,32'h0};
        tbl[22] = '{1,0, 0,0,0,  0,0,0,32'h0,        0,0,0,0, 3,10,11,3,1,32'h9,32'h0};
        tbl[23] = '{0,1, 0,0,0,  1,9,0,32'h42,       0,0,0,0, 3,9,5,  0,0,32'h0,32'h0};
        tbl[24] = '{1,0, 0,0,0,  0,0,0,32'h0,        0,0,0,0, 3,9,5,  3,0,32'h42,32'h11};
        tbl[25] = '{1,0, 1,0,3,  1,0,0,32'hFFFF,     0,0,0,0, 3,0,6,  3,0,32'h0,32'h66};
        tbl[26] = '{1,0, 0,0,0,  0,0,0,32'h0,        0,0,0,0, 1,0,10, 1,0,32'h0,32'h0};

        idle();
        rst = 1'b1;
        rf.rd_en = 2'b11;
        rf.rd_addr = {5'd5, 5'd0};
        rf.disp_en = 1'b1; rf.disp_rd = 5'd5; rf.disp_tag = 4'd3;
        @(negedge clk);
        #2;
        chk("in_reset", 0, 1'b0, 1'b0, 32'h0);
        chk("in_reset", 1, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        idle();

        for (int i = 0; i < 16; i++) begin
            rf.rd_en = 2'b11;
            rf.rd_addr = {5'(2*i+1), 5'(2*i)};
            #2;
            chk("after_reset", 0, 1'b1, 1'b0, 32'h0);
            chk("after_reset", 1, 1'b1, 1'b0, 32'h0);
            tick();
        end

        for (int i = 0; i < 27; i++) begin
            apply(tbl[i]);
            #2;
            chk($sformatf("vec%0d", i), 0, 1'(tbl[i].ev), 1'(tbl[i].eb), tbl[i].ed0);
            chk($sformatf("vec%0d", i), 1, 1'(tbl[i].ev >> 1), 1'(tbl[i].eb >> 1), tbl[i].ed1);
            tick();
        end

        for (int n = 0; n < 3000; n++) begin
            rst = $urandom_range(0, 199) == 0;
            rf.rdy = $urandom_range(0, 9) != 0;
            rf.flush = $urandom_range(0, 49) == 0;
            rf.disp_en = 1'($urandom_range(0, 1));
            rf.disp_rd = 5'($urandom_range(0, 8));
            rf.disp_tag = 4'($urandom);
            rf.cmt_en = 1'($urandom_range(0, 1));
            rf.cmt_rd = 5'($urandom_range(0, 8));
            rf.cmt_tag = $urandom_range(0, 3) != 0 ? mq[rf.cmt_rd] : 4'($urandom);
            rf.cmt_data = $urandom;
            rf.ck_save = $urandom_range(0, 7) == 0;
            rf.ck_save_id = 2'($urandom);
            rf.ck_restore = $urandom_range(0, 15) == 0;
            rf.ck_restore_id = 2'($urandom);
            rf.rd_en = 2'($urandom_range(0, 3)) | 2'($urandom_range(0, 3));
            rf.rd_addr = {5'($urandom_range(0, 8)), 5'($urandom_range(0, 8))};
            #2;
            for (int p = 0; p < 2; p++) begin
                exp_rd(p, v, b, d);
                chk("random", p, v, b, d);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
